// File: rtl/ccip_port_tx_buffer.sv
// ccip_port_tx_buffer: per-port CCI-P Tx request buffer between one AFU and
// one leaf port of the legacy mux tree.
//
// c0 (read) and c1 (write) requests are queued in independent FIFOs and
// drained toward the mux only while the mux's almost-full for that channel
// is low. The AFU sees a local, slack-based almost-full instead. c2 (MMIO
// read response) is registered straight through.
//
// Ports:
//   pClk          clock
//   SoftReset     async, active-high reset (from the leaf's afu_SoftReset)
//   up_RxPort     Rx from mux leaf
//   up_TxPort     Tx to mux leaf (registered)
//   afu_RxPort    Rx to AFU (pass-through, local almost-full bits)
//   afu_TxPort    Tx from AFU
//   overflow_err  sticky: a request arrived while its FIFO could not take it
//   drop_count    [15:0] saturating count of dropped c0+c1 requests
//                 (present only with CCIP_TX_BUFFER_STATS_EN defined)

package ccip_if_pkg;
    typedef struct packed {
        logic [1:0]  vc_sel;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic        sop;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_RspMemHdr;

    typedef struct packed {
        t_ccip_RspMemHdr hdr;
        logic [511:0]    data;
        logic            rspValid;
        logic            mmioRdValid;
        logic            mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_RspMemHdr hdr;
        logic            rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;
endpackage

// One channel: FIFO + registered output stage + local almost-full.
module ccip_tx_chan #(
    parameter int DEPTH = 8,
    parameter int SLACK = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_up_almfull,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_almfull,
    output logic         o_drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic [W-1:0]  r_data;
    logic          w_enq;
    logic          w_deq;

    // No bypass: an entry must sit in the FIFO one cycle before it can leave.
    assign w_deq = (r_count != '0) && !i_up_almfull;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign w_enq = i_valid && ((r_count != CW'(DEPTH)) || w_deq);
    assign o_drop = i_valid && !w_enq;
    assign o_almfull = i_rst | (r_count >= CW'(DEPTH - SLACK));
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Storage is not reset; the cleared count makes stale entries unreachable.
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_deq;
            if (w_deq) begin
                r_data <= r_mem[r_rptr];
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_enq) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CW'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - CW'(1);
            end
        end
    end
endmodule

module ccip_port_tx_buffer
    import ccip_if_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int ALMFULL_SLACK = 4
) (
    input  logic         pClk,
    input  logic         SoftReset,
    input  t_if_ccip_Rx  up_RxPort,
    output t_if_ccip_Tx  up_TxPort,
    output t_if_ccip_Rx  afu_RxPort,
    input  t_if_ccip_Tx  afu_TxPort,
    output logic         overflow_err
`ifdef CCIP_TX_BUFFER_STATS_EN
    ,
    output logic [15:0]  drop_count
`endif
);
    localparam int C0W = $bits(t_ccip_c0_ReqMemHdr);
    localparam int C1W = $bits(t_ccip_c1_ReqMemHdr) + 512;

    logic           w_c0_valid;
    logic [C0W-1:0] w_c0_data;
    logic           w_c0_almfull;
    logic           w_c0_drop;
    logic           w_c1_valid;
    logic [C1W-1:0] w_c1_data;
    logic           w_c1_almfull;
    logic           w_c1_drop;
    t_if_ccip_c2_Tx r_c2;
    logic           r_ovf;

    ccip_tx_chan #(.DEPTH(DEPTH), .SLACK(ALMFULL_SLACK), .W(C0W)) u_c0 (
        .i_clk        (pClk),
        .i_rst        (SoftReset),
        .i_valid      (afu_TxPort.c0.valid),
        .i_data       (afu_TxPort.c0.hdr),
        .i_up_almfull (up_RxPort.c0TxAlmFull),
        .o_valid      (w_c0_valid),
        .o_data       (w_c0_data),
        .o_almfull    (w_c0_almfull),
        .o_drop       (w_c0_drop)
    );

    ccip_tx_chan #(.DEPTH(DEPTH), .SLACK(ALMFULL_SLACK), .W(C1W)) u_c1 (
        .i_clk        (pClk),
        .i_rst        (SoftReset),
        .i_valid      (afu_TxPort.c1.valid),
        .i_data       ({afu_TxPort.c1.hdr, afu_TxPort.c1.data}),
        .i_up_almfull (up_RxPort.c1TxAlmFull),
        .o_valid      (w_c1_valid),
        .o_data       (w_c1_data),
        .o_almfull    (w_c1_almfull),
        .o_drop       (w_c1_drop)
    );

    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            r_c2  <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_c2 <= afu_TxPort.c2;
            if (w_c0_drop || w_c1_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign overflow_err = r_ovf;

    always_comb begin
        afu_RxPort             = up_RxPort;
        afu_RxPort.c0TxAlmFull = w_c0_almfull;
        afu_RxPort.c1TxAlmFull = w_c1_almfull;
    end

    always_comb begin
        up_TxPort          = '0;
        up_TxPort.c0.valid = w_c0_valid;
        up_TxPort.c0.hdr   = w_c0_data;
        up_TxPort.c1.valid = w_c1_valid;
        {up_TxPort.c1.hdr, up_TxPort.c1.data} = w_c1_data;
        up_TxPort.c2       = r_c2;
    end

`ifdef CCIP_TX_BUFFER_STATS_EN
    logic [15:0] r_drop_count;
    logic [16:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_count} + 17'(w_c0_drop)
                      + 17'(w_c1_drop);

    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            r_drop_count <= '0;
        end else begin
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign drop_count = r_drop_count;
`endif
endmodule

// File: tb/tb_ccip_port_tx_buffer.sv
// Testbench for ccip_port_tx_buffer: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_ccip_port_tx_buffer;
    import ccip_if_pkg::*;

    localparam int DEPTH = 8;
    localparam int SLACK = 4;
    localparam int C1W   = $bits(t_ccip_c1_ReqMemHdr) + 512;

    logic        pClk = 1'b0;
    logic        SoftReset = 1'b0;
    t_if_ccip_Rx up_RxPort;
    t_if_ccip_Tx up_TxPort;
    t_if_ccip_Rx afu_RxPort;
    t_if_ccip_Tx afu_TxPort;
    logic        overflow_err;
`ifdef CCIP_TX_BUFFER_STATS_EN
    logic [15:0] drop_count;
`endif

    always #5 pClk = ~pClk;

    ccip_port_tx_buffer #(.DEPTH(DEPTH), .ALMFULL_SLACK(SLACK)) dut (
        .pClk         (pClk),
        .SoftReset    (SoftReset),
        .up_RxPort    (up_RxPort),
        .up_TxPort    (up_TxPort),
        .afu_RxPort   (afu_RxPort),
        .afu_TxPort   (afu_TxPort),
        .overflow_err (overflow_err)
`ifdef CCIP_TX_BUFFER_STATS_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    int errs   = 0;
    int checks = 0;

    t_ccip_c0_ReqMemHdr q0[$];
    logic [C1W-1:0]     q1[$];
    logic               e_c0_vld;
    t_ccip_c0_ReqMemHdr e_c0_hdr;
    logic               e_c1_vld;
    logic [C1W-1:0]     e_c1;
    t_if_ccip_c2_Tx     e_c2;
    logic               e_ovf;
    int                 e_drops;

    task automatic chk(input string tag, input logic [1023:0] got,
                       input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        e_c0_vld = 1'b0;
        e_c0_hdr = '0;
        e_c1_vld = 1'b0;
        e_c1     = '0;
        e_c2     = '0;
        e_ovf    = 1'b0;
        e_drops  = 0;
    endtask

    task automatic rand_payload(input logic c2v);
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        afu_TxPort.c0.hdr = r[65:0];
        r = {$urandom, $urandom, $urandom};
        afu_TxPort.c1.hdr = r[66:0];
        for (int i = 0; i < 16; i++) begin
            afu_TxPort.c1.data[i*32 +: 32] = $urandom;
            up_RxPort.c0.data[i*32 +: 32]  = $urandom;
        end
        afu_TxPort.c2.hdr.tid     = 9'($urandom);
        afu_TxPort.c2.data        = {$urandom, $urandom};
        afu_TxPort.c2.mmioRdValid = c2v;
        r = {$urandom, $urandom, $urandom};
        up_RxPort.c0.hdr         = r[21:0];
        up_RxPort.c1.hdr         = r[43:22];
        up_RxPort.c0.rspValid    = r[44];
        up_RxPort.c0.mmioRdValid = r[45];
        up_RxPort.c0.mmioWrValid = r[46];
        up_RxPort.c1.rspValid    = r[47];
    endtask

    task automatic check_all();
        chk("c0_valid", 1024'(up_TxPort.c0.valid), 1024'(e_c0_vld));
        if (e_c0_vld)
            chk("c0_hdr", 1024'(up_TxPort.c0.hdr), 1024'(e_c0_hdr));
        chk("c1_valid", 1024'(up_TxPort.c1.valid), 1024'(e_c1_vld));
        if (e_c1_vld)
            chk("c1_beat", 1024'({up_TxPort.c1.hdr, up_TxPort.c1.data}),
                1024'(e_c1));
        chk("c2", 1024'(up_TxPort.c2), 1024'(e_c2));
        chk("c0_almfull", 1024'(afu_RxPort.c0TxAlmFull),
            1024'(q0.size() >= DEPTH - SLACK));
        chk("c1_almfull", 1024'(afu_RxPort.c1TxAlmFull),
            1024'(q1.size() >= DEPTH - SLACK));
        chk("overflow_err", 1024'(overflow_err), 1024'(e_ovf));
        chk("rx_pass", 1024'({afu_RxPort.c0, afu_RxPort.c1}),
            1024'({up_RxPort.c0, up_RxPort.c1}));
`ifdef CCIP_TX_BUFFER_STATS_EN
        chk("drop_count", 1024'(drop_count), 1024'(e_drops[15:0]));
`endif
    endtask

    // One clock: drive at negedge, advance model, check at next negedge.
    task automatic cycle(input logic af0, input logic af1, input logic v0,
                         input logic v1, input logic c2v);
        int nd;
        rand_payload(c2v);
        afu_TxPort.c0.valid   = v0;
        afu_TxPort.c1.valid   = v1;
        up_RxPort.c0TxAlmFull = af0;
        up_RxPort.c1TxAlmFull = af1;
        nd = 0;
        e_c0_vld = (q0.size() != 0) && !af0;
        if (e_c0_vld) e_c0_hdr = q0.pop_front();
        if (v0) begin
            if (q0.size() < DEPTH) q0.push_back(afu_TxPort.c0.hdr);
            else nd++;
        end
        e_c1_vld = (q1.size() != 0) && !af1;
        if (e_c1_vld) e_c1 = q1.pop_front();
        if (v1) begin
            if (q1.size() < DEPTH)
                q1.push_back({afu_TxPort.c1.hdr, afu_TxPort.c1.data});
            else nd++;
        end
        if (nd != 0) e_ovf = 1'b1;
        e_drops = (e_drops + nd > 65535) ? 65535 : e_drops + nd;
        e_c2 = afu_TxPort.c2;
        @(posedge pClk);
        @(negedge pClk);
        check_all();
    endtask

    task automatic do_reset();
        SoftReset = 1'b1;
        afu_TxPort.c0.valid = 1'b0;
        afu_TxPort.c1.valid = 1'b0;
        afu_TxPort.c2.mmioRdValid = 1'b0;
        #1;
        chk("rst_c0_valid", 1024'(up_TxPort.c0.valid), 1024'(0));
        chk("rst_c1_valid", 1024'(up_TxPort.c1.valid), 1024'(0));
        chk("rst_c2", 1024'(up_TxPort.c2), 1024'(0));
        chk("rst_c0_almfull", 1024'(afu_RxPort.c0TxAlmFull), 1024'(1));
        chk("rst_c1_almfull", 1024'(afu_RxPort.c1TxAlmFull), 1024'(1));
        chk("rst_overflow", 1024'(overflow_err), 1024'(0));
        model_clear();
        @(posedge pClk);
        @(negedge pClk);
        chk("rst_hold_c1_valid", 1024'(up_TxPort.c1.valid), 1024'(0));
        SoftReset = 1'b0;
        #1;
        chk("post_rst_c0_almfull", 1024'(afu_RxPort.c0TxAlmFull), 1024'(0));
        chk("post_rst_c1_almfull", 1024'(afu_RxPort.c1TxAlmFull), 1024'(0));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int paf[8] = '{0, 80, 20, 95, 50, 0, 60, 10};
        int pv[8]  = '{50, 90, 70, 100, 60, 100, 30, 80};
        afu_TxPort = '0;
        up_RxPort  = '0;
        model_clear();
        @(negedge pClk);
        do_reset();

        // single read, 2-cycle latency
        cycle(0, 0, 1, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // 4 writes held back, then released in order
        repeat (4) cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0, 0);

        // 9 reads while blocked: 9th dropped
        repeat (9) cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0);
        repeat (10) cycle(0, 0, 0, 0, 0);
        do_reset();

        // full FIFO, simultaneous enqueue and dequeue
        repeat (8) cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        repeat (10) cycle(0, 0, 0, 0, 0);

        // reset in the middle of a c1 drain
        repeat (3) cycle(0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        do_reset();
        repeat (4) cycle(0, 0, 0, 0, 0);

        // c2 while c0/c1 are blocked
        cycle(1, 1, 1, 1, 1);
        cycle(1, 1, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 0);

        // random phases of varying pressure
        for (int p = 0; p < 8; p++) begin
            if (p == 4) do_reset();
            for (int i = 0; i < 250; i++) begin
                cycle($urandom_range(99) < paf[p], $urandom_range(99) < paf[p],
                      $urandom_range(99) < pv[p], $urandom_range(99) < pv[p],
                      1'($urandom_range(1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
